// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Word-organised data memory for the load/store port. Loads return
//            one cycle later and illegal accesses are flagged.
// Revision : 1.0
// ============================================================================
module dmem_responder #(
    parameter int              XLEN      = 64,
    parameter int              DEPTH     = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR = 64'h80000000,
    parameter int              CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mren,
    input  logic             mwen,
    input  logic [XLEN-1:0]  addr,
    input  logic [XLEN-1:0]  mwdata,
    output logic [XLEN-1:0]  mrdata,
    output logic             rvalid,
    output logic             err,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    localparam int c_OFF_W = $clog2(XLEN / 8);
    localparam int c_IDX_W = $clog2(DEPTH);

    logic [XLEN-1:0]    r_mem_q [DEPTH];
    logic [XLEN-1:0]    r_mrdata_q, w_mrdata_d;
    logic               r_rvalid_q, w_rvalid_d;
    logic               r_err_q,    w_err_d;
    logic [CNT_W-1:0]   r_rd_cnt_q, w_rd_cnt_d;
    logic [CNT_W-1:0]   r_wr_cnt_q, w_wr_cnt_d;

    logic [XLEN-1:0]    w_offset;
    logic [XLEN-1:0]    w_word_off;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_aligned;
    logic               w_legal;
    logic               w_store;

    always_comb begin
        w_offset   = addr - BASE_ADDR;
        w_word_off = w_offset >> c_OFF_W;
        w_idx      = w_word_off[c_IDX_W-1:0];
        w_aligned  = (addr[c_OFF_W-1:0] == '0);
        w_legal    = w_aligned && (addr >= BASE_ADDR) && (w_word_off < XLEN'(DEPTH));
        // Requests seen while reset is asserted must never touch the array.
        w_store    = rst && mwen && w_legal;
    end

    always_comb begin
        w_mrdata_d = r_mrdata_q;
        w_rvalid_d = 1'b0;
        w_err_d    = 1'b0;
        w_rd_cnt_d = r_rd_cnt_q;
        w_wr_cnt_d = r_wr_cnt_q;
        if (mren || mwen) begin
            if (!w_legal) begin
                w_err_d = 1'b1;
                if (mren) begin
                    w_rvalid_d = 1'b1;
                    w_mrdata_d = '0;
                end
            end else begin
                if (mren) begin
                    // Combinational read sees the pre-edge word: read-before-write.
                    w_rvalid_d = 1'b1;
                    w_mrdata_d = r_mem_q[w_idx];
                    if (r_rd_cnt_q != '1) w_rd_cnt_d = r_rd_cnt_q + CNT_W'(1);
                end
                if (mwen && (r_wr_cnt_q != '1)) w_wr_cnt_d = r_wr_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) r_mem_q[w_idx] <= mwdata;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mrdata_q <= '0;
            r_rvalid_q <= 1'b0;
            r_err_q    <= 1'b0;
            r_rd_cnt_q <= '0;
            r_wr_cnt_q <= '0;
        end else begin
            r_mrdata_q <= w_mrdata_d;
            r_rvalid_q <= w_rvalid_d;
            r_err_q    <= w_err_d;
            r_rd_cnt_q <= w_rd_cnt_d;
            r_wr_cnt_q <= w_wr_cnt_d;
        end
    end

    assign mrdata = r_mrdata_q;
    assign rvalid = r_rvalid_q;
    assign err    = r_err_q;
    assign rd_cnt = r_rd_cnt_q;
    assign wr_cnt = r_wr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed self-checking bench for dmem_responder.
// Revision : 1.0
// ============================================================================
module tb_dmem_responder;

    localparam int c_XLEN = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              mren = 1'b0, mwen = 1'b0;
    logic [c_XLEN-1:0] addr = '0, mwdata = '0;
    logic [c_XLEN-1:0] mrdata;
    logic              rvalid, err;
    logic [31:0]       rd_cnt, wr_cnt;

    logic              s_mren = 1'b0, s_mwen = 1'b0;
    logic [c_XLEN-1:0] s_addr = '0, s_mwdata = '0;
    logic [c_XLEN-1:0] s_mrdata;
    logic              s_rvalid, s_err;
    logic [3:0]        s_rd_cnt, s_wr_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.XLEN(64), .DEPTH(1024), .BASE_ADDR(64'h80000000), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst), .mren(mren), .mwen(mwen), .addr(addr), .mwdata(mwdata),
        .mrdata(mrdata), .rvalid(rvalid), .err(err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
    );

    dmem_responder #(.XLEN(64), .DEPTH(16), .BASE_ADDR(64'h80000000), .CNT_W(4)) u_small (
        .clk(clk), .rst(rst), .mren(s_mren), .mwen(s_mwen), .addr(s_addr), .mwdata(s_mwdata),
        .mrdata(s_mrdata), .rvalid(s_rvalid), .err(s_err), .rd_cnt(s_rd_cnt), .wr_cnt(s_wr_cnt)
    );

    // Present one request for one edge, then sample 1 ns after that edge.
    task automatic cycle(input logic ren, input logic wen, input logic [63:0] a, input logic [63:0] d);
        mren = ren; mwen = wen; addr = a; mwdata = d;
        @(posedge clk); #1;
        mren = 1'b0; mwen = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (mrdata !== 64'h0) begin n_fail++; $display("FAIL reset_mrdata got %h exp %h", mrdata, 64'h0); end
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", err); end
        n_cmp++; if (rd_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_rd_cnt got %0d exp 0", rd_cnt); end
        n_cmp++; if (wr_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_wr_cnt got %0d exp 0", wr_cnt); end
        rst = 1'b1;
    endtask

    task automatic test_store_load();
        cycle(1'b0, 1'b1, 64'h80000008, 64'hDEADBEEF_00000001);
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL st_rvalid got %b exp 0", rvalid); end
        n_cmp++; if (wr_cnt !== 32'd1) begin n_fail++; $display("FAIL st_wr_cnt got %0d exp 1", wr_cnt); end
        cycle(1'b1, 1'b0, 64'h80000008, 64'h0);
        n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL ld_rvalid got %b exp 1", rvalid); end
        n_cmp++; if (mrdata !== 64'hDEADBEEF_00000001) begin n_fail++; $display("FAIL ld_mrdata got %h exp %h", mrdata, 64'hDEADBEEF_00000001); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL ld_err got %b exp 0", err); end
        n_cmp++; if (rd_cnt !== 32'd1) begin n_fail++; $display("FAIL ld_rd_cnt got %0d exp 1", rd_cnt); end
    endtask

    task automatic test_read_before_write();
        cycle(1'b0, 1'b1, 64'h80000000, 64'h11);
        cycle(1'b1, 1'b1, 64'h80000000, 64'h22);
        n_cmp++; if (mrdata !== 64'h11) begin n_fail++; $display("FAIL rbw_old got %h exp %h", mrdata, 64'h11); end
        n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL rbw_rvalid got %b exp 1", rvalid); end
        n_cmp++; if (wr_cnt !== 32'd3) begin n_fail++; $display("FAIL rbw_wr_cnt got %0d exp 3", wr_cnt); end
        cycle(1'b1, 1'b0, 64'h80000000, 64'h0);
        n_cmp++; if (mrdata !== 64'h22) begin n_fail++; $display("FAIL rbw_new got %h exp %h", mrdata, 64'h22); end
        n_cmp++; if (rd_cnt !== 32'd3) begin n_fail++; $display("FAIL rbw_rd_cnt got %0d exp 3", rd_cnt); end
    endtask

    task automatic test_illegal_load();
        logic [63:0] bad [2];
        bad[0] = 64'h80000004;
        bad[1] = 64'h80000000 + 64'd8 * 64'd1024;
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b0, bad[i], 64'h0);
            n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL ill_err[%0d] got %b exp 1", i, err); end
            n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL ill_rvalid[%0d] got %b exp 1", i, rvalid); end
            n_cmp++; if (mrdata !== 64'h0) begin n_fail++; $display("FAIL ill_mrdata[%0d] got %h exp 0", i, mrdata); end
            n_cmp++; if (rd_cnt !== 32'd3) begin n_fail++; $display("FAIL ill_rd_cnt[%0d] got %0d exp 3", i, rd_cnt); end
        end
    endtask

    task automatic test_below_base();
        cycle(1'b0, 1'b1, 64'h7FFFFFF8, 64'h5555);
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL bb_err got %b exp 1", err); end
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL bb_rvalid got %b exp 0", rvalid); end
        n_cmp++; if (wr_cnt !== 32'd3) begin n_fail++; $display("FAIL bb_wr_cnt got %0d exp 3", wr_cnt); end
        cycle(1'b1, 1'b0, 64'h80000008, 64'h0);
        n_cmp++; if (mrdata !== 64'hDEADBEEF_00000001) begin n_fail++; $display("FAIL bb_load got %h exp %h", mrdata, 64'hDEADBEEF_00000001); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL bb_load_err got %b exp 0", err); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_word [3];
        exp_word[0] = 64'h22;
        exp_word[1] = 64'hDEADBEEF_00000001;
        exp_word[2] = 64'h33;
        cycle(1'b0, 1'b1, 64'h80000010, 64'h33);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 64'h80000000 + 64'(8 * i), 64'h0);
            n_cmp++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL b2b_rvalid[%0d] got %b exp 1", i, rvalid); end
            n_cmp++; if (mrdata !== exp_word[i]) begin n_fail++; $display("FAIL b2b_mrdata[%0d] got %h exp %h", i, mrdata, exp_word[i]); end
        end
        cycle(1'b0, 1'b0, 64'h0, 64'h0);
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid got %b exp 0", rvalid); end
        n_cmp++; if (mrdata !== 64'h33) begin n_fail++; $display("FAIL idle_hold got %h exp %h", mrdata, 64'h33); end
        n_cmp++; if (rd_cnt !== 32'd7) begin n_fail++; $display("FAIL b2b_rd_cnt got %0d exp 7", rd_cnt); end
        n_cmp++; if (wr_cnt !== 32'd4) begin n_fail++; $display("FAIL b2b_wr_cnt got %0d exp 4", wr_cnt); end
    endtask

    task automatic test_reset_midstream();
        cycle(1'b1, 1'b0, 64'h80000008, 64'h0);
        rst = 1'b0;
        cycle(1'b1, 1'b1, 64'h80000000, 64'h99);
        n_cmp++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL mid_rvalid got %b exp 0", rvalid); end
        n_cmp++; if (mrdata !== 64'h0) begin n_fail++; $display("FAIL mid_mrdata got %h exp 0", mrdata); end
        n_cmp++; if (rd_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_rd_cnt got %0d exp 0", rd_cnt); end
        n_cmp++; if (wr_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_wr_cnt got %0d exp 0", wr_cnt); end
        rst = 1'b1;
        cycle(1'b1, 1'b0, 64'h80000000, 64'h0);
        n_cmp++; if (mrdata !== 64'h22) begin n_fail++; $display("FAIL mid_retain0 got %h exp %h", mrdata, 64'h22); end
        cycle(1'b1, 1'b0, 64'h80000010, 64'h0);
        n_cmp++; if (mrdata !== 64'h33) begin n_fail++; $display("FAIL mid_retain2 got %h exp %h", mrdata, 64'h33); end
        n_cmp++; if (rd_cnt !== 32'd2) begin n_fail++; $display("FAIL mid_rd_cnt2 got %0d exp 2", rd_cnt); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            s_mwen = 1'b1; s_mren = 1'b0;
            s_addr = 64'h80000000 + 64'(8 * (i % 16));
            s_mwdata = 64'(i);
            @(posedge clk); #1;
            if (i == 13) begin
                n_cmp++; if (s_wr_cnt !== 4'd14) begin n_fail++; $display("FAIL sat_wr_cnt14 got %0d exp 14", s_wr_cnt); end
            end
        end
        s_mwen = 1'b0;
        n_cmp++; if (s_wr_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_wr_cnt got %0d exp 15", s_wr_cnt); end
        s_mren = 1'b1; s_addr = 64'h80000008;
        @(posedge clk); #1;
        s_mren = 1'b0;
        n_cmp++; if (s_mrdata !== 64'd17) begin n_fail++; $display("FAIL sat_load got %h exp %h", s_mrdata, 64'd17); end
        n_cmp++; if (s_rd_cnt !== 4'd1) begin n_fail++; $display("FAIL sat_rd_cnt got %0d exp 1", s_rd_cnt); end
        n_cmp++; if (s_wr_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_wr_hold got %0d exp 15", s_wr_cnt); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_read_before_write();
        test_illegal_load();
        test_below_base();
        test_back_to_back();
        test_reset_midstream();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
